// File: rtl/block_scan_ctrl.sv
// block_scan_ctrl: frame sequencer for 8x8 block coefficient scan.
// Emits one (u,v) beat per valid/ready handshake, 64 per block.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, num_blocks start pulse and block count (latched in IDLE)
//   abort             drop current frame, return to IDLE
//   out_valid/ready   beat handshake
//   u, v, scan_pos    coefficient row/column and position in block
//   blk_idx           0-based block index within the frame
//   out_eob, out_eof  last beat of block / of frame
//   busy, done        frame in progress / one-cycle completion pulse
//
// Build option: define BLOCK_SCAN_ZIGZAG_EN for JPEG zigzag (u,v)
// order; otherwise raster order is used.

module block_scan_ctrl #(
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           u,
  output logic [2:0]           v,
  output logic [5:0]           scan_pos,
  output logic [BLK_CNT_W-1:0] blk_idx,
  output logic                 out_eob,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t               state;
  logic [BLK_CNT_W-1:0] nb_q;
  logic [BLK_CNT_W-1:0] last_blk;

  assign last_blk = nb_q - BLK_CNT_W'(1);

  // Flags decode straight from the registered counters.
  assign out_eob = (state == SCAN) &&
                   (scan_pos == 6'd63);
  assign out_eof = out_eob &&
                   (blk_idx == last_blk);

`ifdef BLOCK_SCAN_ZIGZAG_EN
  // Entry = u*8+v for each scan position.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16,
    6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25,
    6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33,
    6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,
    6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56,
    6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23,
    6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45,
    6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54,
    6'd47, 6'd55, 6'd62, 6'd63
  };
  assign {u, v} = ZZ[scan_pos];
`else
  assign {u, v} = scan_pos;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      nb_q      <= '0;
      scan_pos  <= '0;
      blk_idx   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            nb_q     <= num_blocks;
            scan_pos <= '0;
            blk_idx  <= '0;
            busy     <= 1'b1;
            if (num_blocks != '0) begin
              state     <= SCAN;
              out_valid <= 1'b1;
            end else begin
              // Empty frame: report completion directly.
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            state     <= IDLE;
            scan_pos  <= '0;
            blk_idx   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            if (out_eof) begin
              state     <= DONE;
              scan_pos  <= '0;
              blk_idx   <= '0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              scan_pos <= scan_pos + 6'd1;
              if (out_eob)
                blk_idx <= blk_idx + BLK_CNT_W'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          scan_pos <= '0;
          blk_idx  <= '0;
          busy     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_scan_ctrl.sv
// tb_block_scan_ctrl: scoreboard bench for block_scan_ctrl.
// Expected beats are queued at start and popped on each handshake.

module tb_block_scan_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] num_blocks;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   u;
  logic [2:0]   v;
  logic [5:0]   scan_pos;
  logic [W-1:0] blk_idx;
  logic         out_eob;
  logic         out_eof;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [29:0] sb_q[$];
  int          zr[64];
  int          zc[64];

  block_scan_ctrl #(.BLK_CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_blocks (num_blocks),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .u          (u),
    .v          (v),
    .scan_pos   (scan_pos),
    .blk_idx    (blk_idx),
    .out_eob    (out_eob),
    .out_eof    (out_eof),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] beat();
    return {u, v, scan_pos, blk_idx, out_eob, out_eof};
  endfunction

  // All observable outputs; zero in idle.
  function automatic logic [63:0] all_out();
    return {31'd0, out_valid, beat(), busy, done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zigzag walk along anti-diagonals.
  task automatic build_zz();
    int r = 0;
    int c = 0;
    for (int i = 0; i < 64; i++) begin
      zr[i] = r;
      zc[i] = c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endtask

  task automatic push_beats(input int nb, input int cnt);
    int n = 0;
    for (int b = 0; b < nb; b++)
      for (int p = 0; p < 64; p++) begin
        logic [2:0] eu, ev;
        logic       eob, eof;
        if (n < cnt) begin
`ifdef BLOCK_SCAN_ZIGZAG_EN
          eu = 3'(zr[p]);
          ev = 3'(zc[p]);
`else
          eu = 3'(p / 8);
          ev = 3'(p % 8);
`endif
          eob = (p == 63);
          eof = eob && (b == nb - 1);
          sb_q.push_back({eu, ev, 6'(p), W'(b),
                          eob, eof});
        end
        n++;
      end
  endtask

  // Monitor: pop on handshake, hold-check on stalls.
  logic        stall_q = 1'b0;
  logic [29:0] held;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_q && out_valid)
        check("stall_hold", beat(), held);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0)
          check("extra_beat", 1, 0);
        else
          check("beat", beat(), sb_q.pop_front());
      end
    end
    stall_q = !rst && out_valid && !out_ready;
    held    = beat();
  end

  task automatic run_frame(input int nb, input bit tog);
    int n = 0;
    int bound = nb * 128 + 20;
    push_beats(nb, nb * 64);
    out_ready  = 1'b1;
    num_blocks = W'(nb);
    start      = 1'b1;
    tick();
    start = 1'b0;
    check("valid_after_start", out_valid, 1);
    while (!done && n < bound) begin
      if (tog) out_ready = ~out_ready;
      tick();
      n++;
    end
    check("done_seen", done, 1);
    if (!tog) check("frame_len", n, nb * 64);
    check("done_busy", {busy, out_valid}, 2'b10);
    check("sb_empty", sb_q.size(), 0);
    out_ready = 1'b1;
    tick();
    check("after_done", {done, busy}, 2'b00);
  endtask

  task automatic wait_pos(input int b, input int p);
    int n = 0;
    while (!(blk_idx == W'(b) && scan_pos == 6'(p))
           && n < 400) begin
      tick();
      n++;
    end
    check("reach_pos", n < 400, 1);
  endtask

  initial begin
    build_zz();
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    num_blocks = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("reset_outs", all_out(), 0);
    rst = 1'b0;
    tick();

    // Single block, ready held high.
    run_frame(1, 1'b0);

    // Three blocks with alternating backpressure.
    run_frame(3, 1'b1);

    // Empty frame; start during DONE is ignored.
    num_blocks = '0;
    start      = 1'b1;
    tick();
    check("nb0_done", {done, busy, out_valid}, 3'b110);
    num_blocks = W'(5);
    tick();
    start = 1'b0;
    check("nb0_idle", {done, busy, out_valid}, 3'b000);
    tick();
    check("nb0_ignored", {busy, out_valid}, 2'b00);

    // Abort at block 1, position 10.
    push_beats(2, 74);
    num_blocks = W'(2);
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_pos(1, 10);
    out_ready = 1'b0;
    abort     = 1'b1;
    tick();
    abort     = 1'b0;
    out_ready = 1'b1;
    check("abort_idle", all_out(), 0);
    check("abort_sb", sb_q.size(), 0);
    sb_q.delete();
    tick();
    check("abort_no_done", {done, busy}, 2'b00);
    run_frame(1, 1'b0);

    // Reset mid-block, then start+abort together.
    push_beats(2, 37);
    num_blocks = W'(2);
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_pos(0, 37);
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    check("rst_mid", all_out(), 0);
    check("rst_sb", sb_q.size(), 0);
    sb_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    abort     = 1'b1;
    num_blocks = W'(4);
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort", all_out(), 0);
    tick();
    check("stay_idle", all_out(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_scan_ctrl.md
Name: block_scan_ctrl

Overview:
- Frame-level sequencer for the 8x8 block coefficient scan in the image codec.
- Accepts a start command with a block count, then emits one (u,v) coordinate per accepted beat over a valid/ready interface.
- Emits 64 coordinates per block and walks consecutive blocks until the frame is done, flagging end-of-block and end-of-frame.
- Sits between the frame-control logic and the coefficient buffer/transform stages; downstream backpressure stalls the scan.

Parameters:
BLK_CNT_W, 16, width of block count and block index; max frame size 2^BLK_CNT_W - 1 blocks

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  start-frame pulse; sampled only in IDLE
num_blocks  input  BLK_CNT_W  blocks in frame; latched on accepted start
abort  input  1  terminate current frame; returns to IDLE
out_valid  output  1  coordinate beat valid
out_ready  input  1  downstream accepts beat
u  output  3  row index of current coefficient
v  output  3  column index of current coefficient
scan_pos  output  6  position 0..63 of current beat within block
blk_idx  output  BLK_CNT_W  index of current block, 0-based
out_eob  output  1  current beat is the last of its block (scan_pos==63)
out_eof  output  1  current beat is the last of the frame (out_eob and blk_idx==latched num_blocks-1)
busy  output  1  high in SCAN and DONE
done  output  1  one-cycle pulse on frame completion

Behaviour:
- Reset: state IDLE; out_valid=0, u=0, v=0, scan_pos=0, blk_idx=0, out_eob=0, out_eof=0, busy=0, done=0. Reset mid-frame discards the frame with no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE, start=1, abort=0, num_blocks!=0: latch num_blocks, clear scan_pos and blk_idx, go to SCAN. out_valid is 1 on the next cycle.
- IDLE, start=1, num_blocks==0: go to DONE with no beats emitted.
- IDLE, start=1 and abort=1 in the same cycle: abort wins; stay in IDLE with nothing latched.
- SCAN: out_valid=1 continuously.
  - A beat is accepted when out_valid and out_ready are both high. On acceptance, scan_pos increments.
  - scan_pos 63 wraps to 0 and blk_idx increments.
  - If the accepted beat has out_eof=1, go to DONE; out_valid is 0 next cycle.
- Stall: while out_valid=1 and out_ready=0, u, v, scan_pos, blk_idx, out_eob and out_eof hold stable.
- Coordinate generation:
  - Default raster order: u = scan_pos[5:3], v = scan_pos[2:0] (v inner, u outer).
  - u, v and the eob/eof flags are combinational from registered scan_pos and blk_idx, so there is zero latency from state to outputs.
- DONE: done=1 for exactly one cycle, out_valid=0, then go to IDLE. start is ignored in DONE.
- start while busy is ignored and num_blocks is not re-latched.
- abort in SCAN or DONE: next state IDLE and counters clear. No done pulse, even if abort coincides with the eof handshake. abort in IDLE is a no-op.
- Wrap-around: blk_idx never exceeds num_blocks-1; the frame ends before any overflow. num_blocks = 2^BLK_CNT_W - 1 is legal.
- In IDLE and DONE, u/v/scan_pos/blk_idx read 0 after clearing and out_eob=out_eof=0.

Optional Feature:
Macro BLOCK_SCAN_ZIGZAG_EN.
- Defined: u and v follow JPEG zigzag order through a 64-entry constant table indexed by scan_pos. Zigzag linear index = u*8+v, with sequence 0,1,8,16,9,2,3,10,17,24,... ending 63. For example, scan_pos=2 gives u=1, v=0, and scan_pos=63 gives u=7, v=7.
- Not defined: raster order as above, with no table present.
- In both cases scan_pos, out_eob, out_eof and the handshake are unchanged.

Test Plan:
- Reset, then start with num_blocks=1 and out_ready=1 held: 64 beats on consecutive cycles; first beat u=0,v=0; beat 9 u=1,v=0; beat 64 u=7,v=7 with out_eob=out_eof=1; done pulses 1 cycle after the last beat; busy falls the cycle after that.
- num_blocks=3, out_ready toggling 1/0 each cycle: 192 accepted beats; outputs stable on stalled cycles; blk_idx steps 0→1→2 at each scan_pos wrap; out_eob on 3 beats; out_eof only on the last.
- start with num_blocks=0: no out_valid; done pulse 1 cycle after start; start during that DONE cycle is ignored.
- num_blocks=2, abort asserted at blk_idx=1, scan_pos=10: IDLE next cycle; out_valid=0; no done; new start then scans from u=0,v=0,blk_idx=0.
- Synchronous rst asserted mid-block (scan_pos=37), then start/abort same-cycle in IDLE: all outputs 0 after reset; state stays IDLE.
- With BLOCK_SCAN_ZIGZAG_EN, num_blocks=1: beats 0..5 give (u,v) = (0,0),(0,1),(1,0),(2,0),(1,1),(0,2); beat 63 gives (7,7) with out_eof=1.
